// File: rtl/counter4_sequencer.sv
// counter4_sequencer
//
// Shares one Counter4 (universal 4-bit counter/shift register) between two
// requesters, A and B. A granted command (Mode, Din, R_In, L_In) is held on
// the Counter4 control pins for max(Len,1) clock cycles. The counter is then
// parked on HOLD_MODE and the owner gets a one-cycle Done pulse.
//
// Handshake: ReqX is a level request that the requester holds until it sees
// GntX. GntX is a one-cycle pulse. On the edge that produces it, the command
// fields of X are captured, so later changes to ModeX/DinX/... have no effect.
// DoneX pulses for one cycle when the command has finished. Requests are only
// looked at in IDLE. A request still high on return to IDLE is a new request.
//
// Ports
//   Ck                      clock, all state changes on posedge
//   Reset                   synchronous, active-low
//   ReqA/ReqB               level requests
//   ModeX, DinX, RInX, LInX command fields for requester X
//   LenX                    command length in cycles (0 behaves as 1)
//   GntA/GntB               one-cycle grant pulse (command captured)
//   DoneA/DoneB             one-cycle completion pulse
//   Busy                    a command is granted and not yet completed
//   Owner                   0 = A, 1 = B; meaningful while Busy
//   Mode, Din, R_In, L_In   Counter4 control pins
//   fsm_state               current FSM state (IDLE=0, RUN=1, DONE=2)

module counter4_sequencer #(
    parameter int          LEN_W     = 4,
    parameter logic [2:0]  HOLD_MODE = 3'b000
) (
    input  logic             Ck,
    input  logic             Reset,
    input  logic             ReqA,
    input  logic [2:0]       ModeA,
    input  logic [3:0]       DinA,
    input  logic             RInA,
    input  logic             LInA,
    input  logic [LEN_W-1:0] LenA,
    input  logic             ReqB,
    input  logic [2:0]       ModeB,
    input  logic [3:0]       DinB,
    input  logic             RInB,
    input  logic             LInB,
    input  logic [LEN_W-1:0] LenB,
    output logic             GntA,
    output logic             GntB,
    output logic             DoneA,
    output logic             DoneB,
    output logic             Busy,
    output logic             Owner,
    output logic [2:0]       Mode,
    output logic [3:0]       Din,
    output logic             R_In,
    output logic             L_In,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state, state_next;
    logic [LEN_W-1:0] remaining, remaining_next;
    // prio = 0: A wins a tie, prio = 1: B wins a tie.
    logic             prio, prio_next;
    logic             winner_b;

    logic             gnt_a_next, gnt_b_next, done_a_next, done_b_next;
    logic             busy_next, owner_next;
    logic [2:0]       mode_next;
    logic [3:0]       din_next;
    logic             r_in_next, l_in_next;

    assign fsm_state = state;

    // B wins when it is the only requester, or when both request and the
    // tie-break flag favours B.
    assign winner_b = ReqB && (!ReqA || prio);

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        prio_next      = prio;
        gnt_a_next     = 1'b0;
        gnt_b_next     = 1'b0;
        done_a_next    = 1'b0;
        done_b_next    = 1'b0;
        busy_next      = Busy;
        owner_next     = Owner;
        mode_next      = Mode;
        din_next       = Din;
        r_in_next      = R_In;
        l_in_next      = L_In;

        case (state)
            IDLE: begin
                mode_next = HOLD_MODE;
                din_next  = 4'b0000;
                r_in_next = 1'b0;
                l_in_next = 1'b0;
                busy_next = 1'b0;
                if (ReqA || ReqB) begin
                    state_next = RUN;
                    busy_next  = 1'b1;
                    owner_next = winner_b;
                    prio_next  = !winner_b;
                    if (winner_b) begin
                        gnt_b_next     = 1'b1;
                        mode_next      = ModeB;
                        din_next       = DinB;
                        r_in_next      = RInB;
                        l_in_next      = LInB;
                        remaining_next = (LenB == '0) ? LEN_ONE : LenB;
                    end else begin
                        gnt_a_next     = 1'b1;
                        mode_next      = ModeA;
                        din_next       = DinA;
                        r_in_next      = RInA;
                        l_in_next      = LInA;
                        remaining_next = (LenA == '0) ? LEN_ONE : LenA;
                    end
                end
            end

            RUN: begin
                // The output registers themselves hold the captured command.
                // Leaving on remaining <= 1 (not just == 1) keeps a corrupted
                // counter from wrapping into a 2^LEN_W-cycle command.
                if (remaining <= LEN_ONE) begin
                    state_next  = DONE;
                    mode_next   = HOLD_MODE;
                    din_next    = 4'b0000;
                    r_in_next   = 1'b0;
                    l_in_next   = 1'b0;
                    done_a_next = !Owner;
                    done_b_next = Owner;
                end else begin
                    remaining_next = remaining - LEN_ONE;
                end
            end

            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end

            default: begin
                state_next = IDLE;
                mode_next  = HOLD_MODE;
                din_next   = 4'b0000;
                r_in_next  = 1'b0;
                l_in_next  = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Ck) begin
        if (!Reset) begin
            state     <= IDLE;
            remaining <= '0;
            prio      <= 1'b0;
            GntA      <= 1'b0;
            GntB      <= 1'b0;
            DoneA     <= 1'b0;
            DoneB     <= 1'b0;
            Busy      <= 1'b0;
            Owner     <= 1'b0;
            Mode      <= HOLD_MODE;
            Din       <= 4'b0000;
            R_In      <= 1'b0;
            L_In      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            prio      <= prio_next;
            GntA      <= gnt_a_next;
            GntB      <= gnt_b_next;
            DoneA     <= done_a_next;
            DoneB     <= done_b_next;
            Busy      <= busy_next;
            Owner     <= owner_next;
            Mode      <= mode_next;
            Din       <= din_next;
            R_In      <= r_in_next;
            L_In      <= l_in_next;
        end
    end

endmodule

// File: tb/tb_counter4_sequencer.sv
module tb_counter4_sequencer;

    // ---------------- clock / reset ----------------
    logic Ck = 1'b0;
    always #5 Ck = ~Ck;

    logic       Reset = 1'b0;
    logic       ReqA = 1'b0, RInA = 1'b0, LInA = 1'b0;
    logic [2:0] ModeA = 3'b000;
    logic [3:0] DinA = 4'b0000, LenA = 4'd0;
    logic       ReqB = 1'b0, RInB = 1'b0, LInB = 1'b0;
    logic [2:0] ModeB = 3'b000;
    logic [3:0] DinB = 4'b0000, LenB = 4'd0;
    logic       GntA, GntB, DoneA, DoneB, Busy, Owner, R_In, L_In;
    logic [2:0] Mode;
    logic [3:0] Din;
    logic [1:0] fsm_state;

    counter4_sequencer #(.LEN_W(4), .HOLD_MODE(3'b000)) dut (
        .Ck(Ck), .Reset(Reset),
        .ReqA(ReqA), .ModeA(ModeA), .DinA(DinA), .RInA(RInA), .LInA(LInA), .LenA(LenA),
        .ReqB(ReqB), .ModeB(ModeB), .DinB(DinB), .RInB(RInB), .LInB(LInB), .LenB(LenB),
        .GntA(GntA), .GntB(GntB), .DoneA(DoneA), .DoneB(DoneB),
        .Busy(Busy), .Owner(Owner),
        .Mode(Mode), .Din(Din), .R_In(R_In), .L_In(L_In),
        .fsm_state(fsm_state)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Entry: {owner, mode[2:0], din[3:0], r_in, l_in, cycles[3:0]}
    logic [13:0] exp_q[$];
    bit          prio_b = 1'b0;   // bench's own view of who wins a tie
    bit          mon_en = 1'b0;

    task automatic push_cmd(input bit who);
        logic [3:0] len;
        if (who) begin
            len = (LenB == 4'd0) ? 4'd1 : LenB;
            exp_q.push_back({1'b1, ModeB, DinB, RInB, LInB, len});
        end else begin
            len = (LenA == 4'd0) ? 4'd1 : LenA;
            exp_q.push_back({1'b0, ModeA, DinA, RInA, LInA, len});
        end
        prio_b = !who;
    endtask

    // Monitor: pops an expectation on each grant, checks the pins for every
    // RUN cycle, and checks length/owner when Done appears.
    logic [13:0] cur = '0;
    bit          active = 1'b0;
    int          run_cnt = 0;

    always @(negedge Ck) begin
        if (!mon_en) begin
            active = 1'b0;
        end else begin
            if (GntA || GntB) begin
                check("gnt_onehot", 32'(GntA && GntB), 32'd0);
                check("gnt_while_active", 32'(active), 32'd0);
                if (exp_q.size() == 0) begin
                    check("gnt_unexpected", 32'd1, 32'd0);
                    active = 1'b0;
                end else begin
                    cur     = exp_q.pop_front();
                    active  = 1'b1;
                    run_cnt = 0;
                    check("gnt_who", 32'(GntB), 32'(cur[13]));
                end
            end
            if (DoneA || DoneB) begin
                check("done_with_gnt", 32'(GntA || GntB), 32'd0);
                check("done_onehot", 32'(DoneA && DoneB), 32'd0);
                check("done_active", 32'(active), 32'd1);
                check("done_owner", 32'(DoneB), 32'(cur[13]));
                check("run_len", 32'(run_cnt), 32'(cur[3:0]));
                check("done_mode", 32'(Mode), 32'd0);
                check("done_din", 32'(Din), 32'd0);
                check("done_busy", 32'(Busy), 32'd1);
                active = 1'b0;
            end else if (active) begin
                run_cnt++;
                check("run_mode", 32'(Mode), 32'(cur[12:10]));
                check("run_din", 32'(Din), 32'(cur[9:6]));
                check("run_rin", 32'(R_In), 32'(cur[5]));
                check("run_lin", 32'(L_In), 32'(cur[4]));
                check("run_owner", 32'(Owner), 32'(cur[13]));
                check("run_busy", 32'(Busy), 32'd1);
                if (run_cnt > 20) begin
                    check("run_overflow", 32'(run_cnt), 32'(cur[3:0]));
                    active = 1'b0;
                end
            end else if (!(GntA || GntB)) begin
                check("idle_busy", 32'(Busy), 32'd0);
                check("idle_mode", 32'(Mode), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_gnt(output bit got_b, output int n);
        bit ok = 1'b0;
        got_b = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Ck);
            n++;
            if (GntA || GntB) begin
                ok = 1'b1;
                got_b = GntB;
                break;
            end
        end
        if (!ok) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Ck);
            if (!Busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic drop_req(input bit who);
        if (who) ReqB = 1'b0;
        else     ReqA = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit got_b;
        int n;
        bit first;
        int who;

        // Reset held two cycles with ReqA high: nothing may be granted.
        ModeA = 3'b011; DinA = 4'b1010; LenA = 4'd3; ReqA = 1'b1;
        repeat (2) @(negedge Ck);
        check("rst_mode", 32'(Mode), 32'd0);
        check("rst_din", 32'(Din), 32'd0);
        check("rst_rin_lin", 32'({R_In, L_In}), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_gnt", 32'({GntA, GntB}), 32'd0);
        check("rst_owner", 32'(Owner), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);

        // Release: GntA next cycle, Mode=011/Din=1010 for 3 cycles, DoneA in 4th.
        push_cmd(1'b0);
        Reset = 1'b1;
        mon_en = 1'b1;
        wait_gnt(got_b, n);
        ReqA = 1'b0;
        check("rel_gnt_latency", 32'(n), 32'd1);
        check("a_gnt", 32'(GntA), 32'd1);
        check("a_c1_mode", 32'(Mode), 32'h3);
        check("a_c1_din", 32'(Din), 32'ha);
        @(negedge Ck); check("a_c2_mode", 32'(Mode), 32'h3);
        @(negedge Ck); check("a_c3_mode", 32'(Mode), 32'h3);
        @(negedge Ck); check("a_c4_donea", 32'(DoneA), 32'd1);
        check("a_c4_mode", 32'(Mode), 32'd0);
        @(negedge Ck); check("a_c5_busy", 32'(Busy), 32'd0);

        // B with Len=0 runs exactly one cycle.
        ModeB = 3'b101; DinB = 4'b1001; LenB = 4'd0; ReqB = 1'b1;
        push_cmd(1'b1);
        wait_gnt(got_b, n);
        ReqB = 1'b0;
        check("b0_gnt_b", 32'(got_b), 32'd1);
        check("b0_mode", 32'(Mode), 32'h5);
        @(negedge Ck);
        check("b0_doneb", 32'(DoneB), 32'd1);
        check("b0_mode_after", 32'(Mode), 32'd0);
        wait_idle();

        // Both requesting continuously: A,B,A,B spaced Len+2 = 4 cycles.
        ModeA = 3'b001; DinA = 4'b0011; LenA = 4'd2; RInA = 1'b1;
        ModeB = 3'b110; DinB = 4'b1100; LenB = 4'd2; LInB = 1'b1;
        push_cmd(1'b0); push_cmd(1'b1); push_cmd(1'b0); push_cmd(1'b1);
        ReqA = 1'b1; ReqB = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(got_b, n);
            check("alt_order", 32'(got_b), 32'(k % 2));
            check("alt_owner", 32'(Owner), 32'(k % 2));
            if (k > 0) check("alt_spacing", 32'(n), 32'd4);
        end
        ReqA = 1'b0; ReqB = 1'b0;
        RInA = 1'b0; LInB = 1'b0;
        wait_idle();

        // Reset in RUN cycle 4 of a 10-cycle command: dropped without Done.
        ModeA = 3'b100; DinA = 4'b0110; LenA = 4'd10; ReqA = 1'b1;
        push_cmd(1'b0);
        wait_gnt(got_b, n);
        ReqA = 1'b0;
        repeat (3) @(negedge Ck);
        Reset = 1'b0;
        mon_en = 1'b0;
        exp_q.delete();
        prio_b = 1'b0;
        @(negedge Ck);
        check("midrst_donea", 32'(DoneA), 32'd0);
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_mode", 32'(Mode), 32'd0);
        check("midrst_din", 32'(Din), 32'd0);
        check("midrst_state", 32'(fsm_state), 32'd0);
        Reset = 1'b1;
        @(negedge Ck);
        check("midrst_no_done", 32'({DoneA, DoneB}), 32'd0);
        mon_en = 1'b1;
        ModeA = 3'b001; LenA = 4'd1; ModeB = 3'b010; LenB = 4'd1;
        push_cmd(1'b0);
        ReqA = 1'b1; ReqB = 1'b1;
        wait_gnt(got_b, n);
        ReqA = 1'b0; ReqB = 1'b0;
        check("midrst_prio_a", 32'(got_b), 32'd0);
        wait_idle();

        // Command fields changed after grant must not reach the pins.
        ModeA = 3'b010; DinA = 4'b0101; LenA = 4'd5; ReqA = 1'b1;
        push_cmd(1'b0);
        wait_gnt(got_b, n);
        ReqA = 1'b0;
        ModeA = 3'b111; DinA = 4'b1111;
        @(negedge Ck);
        check("late_change_mode", 32'(Mode), 32'h2);
        wait_idle();

        // Random commands: single requester or both at once.
        for (int it = 0; it < 10; it++) begin
            ModeA = 3'($urandom_range(0, 7)); DinA = 4'($urandom_range(0, 15));
            RInA = 1'($urandom_range(0, 1)); LInA = 1'($urandom_range(0, 1));
            LenA = 4'($urandom_range(0, 6));
            ModeB = 3'($urandom_range(0, 7)); DinB = 4'($urandom_range(0, 15));
            RInB = 1'($urandom_range(0, 1)); LInB = 1'($urandom_range(0, 1));
            LenB = 4'($urandom_range(0, 6));
            who = $urandom_range(0, 2);
            if (who < 2) begin
                push_cmd(who[0]);
                if (who == 1) ReqB = 1'b1; else ReqA = 1'b1;
                wait_gnt(got_b, n);
                drop_req(who[0]);
                check("rnd_single_who", 32'(got_b), 32'(who));
            end else begin
                first = prio_b;
                push_cmd(first);
                push_cmd(!first);
                ReqA = 1'b1; ReqB = 1'b1;
                wait_gnt(got_b, n);
                drop_req(first);
                check("rnd_tie_first", 32'(got_b), 32'(first));
                wait_gnt(got_b, n);
                drop_req(!first);
                check("rnd_tie_second", 32'(got_b), 32'(!first));
            end
            wait_idle();
        end

        repeat (2) @(negedge Ck);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter4_sequencer.md
# counter4_sequencer

Two-port command sequencer that shares one Counter4 (universal 4-bit counter/shift register) between requesters A and B. Each requester submits a command (Mode, Din, R_In, L_In, length); the block arbitrates round-robin, drives the granted command onto the Counter4 control inputs for the requested number of Ck cycles, then parks the counter and reports completion. It sits directly in front of the Counter4 control pins; Counter4's Out is not routed through this block.

## Interface
- LEN_W, 4, width of command length field (cycles to apply command)
- HOLD_MODE, 3'b000, Mode value driven whenever no command is running
- Ck  input  1  clock, all state changes on posedge
- Reset  input  1  synchronous, active-low reset: sampled on posedge Ck, Reset=0 resets the block
- ReqA  input  1  requester A command request, level, held until GntA
- ModeA  input  3  A command Mode
- DinA  input  4  A command Din
- RInA  input  1  A command R_In
- LInA  input  1  A command L_In
- LenA  input  LEN_W  A command length in cycles (0 treated as 1)
- ReqB, ModeB, DinB, RInB, LInB, LenB  input  same as A  requester B
- GntA, GntB  output  1  one-cycle grant pulse; command latched
- DoneA, DoneB  output  1  one-cycle completion pulse
- Busy  output  1  high while a command is granted and not yet completed
- Owner  output  1  0=A, 1=B; valid while Busy
- Mode  output  3  to Counter4 Mode
- Din  output  4  to Counter4 Din
- R_In, L_In  output  1  to Counter4 R_In / L_In

## Operation
- FSM states: IDLE, RUN, DONE. All outputs registered.
- IDLE: Mode=HOLD_MODE, Din=0, R_In=L_In=0, Busy=0. On an edge with ReqA|ReqB: select winner, latch its Mode/Din/RIn/LIn, load remaining=max(Len,1), go RUN.
- Arbitration: only one requesting -> it wins. Both -> winner is the one not served last (priority flag). Flag = A after reset; toggles to the other requester on each grant.
- RUN: Mode/Din/R_In/L_In hold latched values; remaining decrements each edge; on edge where remaining==1 go DONE.
- DONE: Mode=HOLD_MODE, Din=0, R_In=L_In=0; Done for Owner high this cycle; Busy still 1; next edge -> IDLE.
- Req/Cmd inputs are ignored outside IDLE; command fields change after Gnt have no effect. A Req still high when back in IDLE is a new request.
- Len width rule: remaining is LEN_W bits, max command length 2^LEN_W-1 cycles; Len=0 gives exactly 1 cycle.
- Reset (Reset=0 at an edge), any state: next cycle state=IDLE, Mode=HOLD_MODE, Din=4'b0000, R_In=L_In=0, GntA=GntB=DoneA=DoneB=0, Busy=0, Owner=0, priority flag=A. A command in progress is dropped without Done.

## Timing
- Request sampled at edge e (state IDLE): cycle after e has Gnt=1, Busy=1, state RUN, command on Counter4 pins.
- Command drives Counter4 for exactly max(Len,1) cycles, i.e. max(Len,1) Counter4 posedges see the command.
- Done pulses in the cycle immediately after the last RUN cycle; back in IDLE one cycle later.
- Request-to-grant latency 1 cycle from IDLE; back-to-back commands: Gnt of next command 3 cycles after the previous DONE cycle begins? No: DONE cycle -> IDLE cycle (request sampled at its end edge) -> Gnt cycle; i.e. min gap between RUN periods = 2 cycles (DONE, IDLE).
- Total occupancy per command: Len+2 cycles (RUN×Len, DONE, IDLE), Len>=1.
- Gnt and Done are never high in the same cycle; GntA and GntB never both high.

## Test plan
- Reset: hold Reset=0 two cycles with ReqA=1 -> Mode=000, Din=0000, R_In=L_In=0, Busy=0, no Gnt; release -> GntA next cycle.
- Single A command ModeA=011, DinA=1010, LenA=3 -> GntA 1 cycle, Mode=011/Din=1010 exactly 3 cycles, DoneA in 4th cycle, Mode=000 from 4th cycle, Busy low in 5th.
- Simultaneous ReqA=ReqB=1 held, LenA=LenB=2 -> grants alternate A,B,A,B; no Gnt in DONE/IDLE cycles; Owner matches grant.
- LenB=0, ModeB=101 -> Mode=101 for exactly 1 cycle, DoneB next cycle.
- Reset=0 mid-RUN of LenA=10 at cycle 4 -> next cycle IDLE outputs, no DoneA, priority back to A (simultaneous requests then grant A).
- Change ModeA from 010 to 111 after GntA during RUN -> Mode stays 010 for full length.
